// File: rtl/riscv_defines.sv
// Shared RV32 definitions for the store buffer: entry layout and default depth.
package riscv_defines;

  localparam int SB_XLEN          = 32;
  localparam int SB_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic                 valid;
    logic [SB_XLEN-1:0]   addr;
    logic [SB_XLEN-1:0]   wdata;
    logic [SB_XLEN/8-1:0] be;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store buffer bundle: enqueue from MEM, drain to data memory, load lookup and status.
interface store_buffer_if
  import riscv_defines::*;
#(
  parameter int XLEN  = SB_XLEN,
  parameter int DEPTH = SB_DEPTH_DEFAULT
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              enq_valid;
  logic              enq_ready;
  logic [XLEN-1:0]   enq_addr;
  logic [XLEN-1:0]   enq_wdata;
  logic [XLEN/8-1:0] enq_be;

  logic              drain_valid;
  logic              drain_ready;
  logic [XLEN-1:0]   drain_addr;
  logic [XLEN-1:0]   drain_wdata;
  logic [XLEN/8-1:0] drain_be;

  logic              ld_valid;
  logic [XLEN-1:0]   ld_addr;
  logic [XLEN-1:0]   fwd_data;
  logic [XLEN/8-1:0] fwd_be;
  logic              ld_stall;

  logic              empty;
  logic              full;
  logic [CW-1:0]     count;

  modport master (
    output enq_valid, enq_addr, enq_wdata, enq_be, drain_ready, ld_valid, ld_addr,
    input  enq_ready, drain_valid, drain_addr, drain_wdata, drain_be,
           fwd_data, fwd_be, ld_stall, empty, full, count
  );

  modport slave (
    input  enq_valid, enq_addr, enq_wdata, enq_be, drain_ready, ld_valid, ld_addr,
    output enq_ready, drain_valid, drain_addr, drain_wdata, drain_be,
           fwd_data, fwd_be, ld_stall, empty, full, count
  );

endinterface

// File: rtl/sb_byte_merge.sv
// Per-byte youngest-match select for store-to-load forwarding.
// Inputs are presented oldest first, so a later hit overrides an earlier one.
module sb_byte_merge #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic [XLEN-1:0]   wdata_age [DEPTH],
  input  logic [XLEN/8-1:0] be_age    [DEPTH],
  input  logic [DEPTH-1:0]  hit_age,
  output logic [XLEN-1:0]   fwd_data,
  output logic [XLEN/8-1:0] fwd_be
);
  localparam int NB = XLEN / 8;

  always_comb begin
    fwd_data = '0;
    fwd_be   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int b = 0; b < NB; b++) begin
        if (hit_age[k] && be_age[k][b]) begin
          fwd_be[b]          = 1'b1;
          fwd_data[b*8 +: 8] = wdata_age[k][b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer with word-granular load lookup.
// STORE_BUFFER_FWD_EN selects byte forwarding; otherwise a matching load raises ld_stall.
module store_buffer
  import riscv_defines::*;
#(
  parameter int XLEN  = SB_XLEN,
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entries use the shared RV32 layout, so only matching widths elaborate.
  if (XLEN != SB_XLEN || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("store_buffer: XLEN must equal SB_XLEN and DEPTH must be a power of two >= 2");
  end

  sb_entry_t        entries_q [DEPTH];
  sb_entry_t        entries_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty;
  logic             do_enq, do_drain;
  logic [DEPTH-1:0] hit;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_enq   = sb.enq_valid && !full;
  assign do_drain = sb.drain_ready && !empty;

  assign sb.enq_ready   = !full;
  assign sb.drain_valid = !empty;
  assign sb.empty       = empty;
  assign sb.full        = full;
  assign sb.count       = count_q;
  assign sb.drain_addr  = entries_q[head_q].addr;
  assign sb.drain_wdata = entries_q[head_q].wdata;
  assign sb.drain_be    = entries_q[head_q].be;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (do_enq) begin
      entries_d[tail_q].valid = 1'b1;
      entries_d[tail_q].addr  = sb.enq_addr;
      entries_d[tail_q].wdata = sb.enq_wdata;
      entries_d[tail_q].be    = sb.enq_be;
      tail_d                  = tail_q + PW'(1);
    end
    if (do_drain) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + PW'(1);
    end
    case ({do_enq, do_drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Word match ignores the byte offset; lookup sees registered state only,
  // so a store enqueuing this cycle is invisible and a draining one still hits.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = entries_q[i].valid && (((entries_q[i].addr ^ sb.ld_addr) >> 2) == '0);
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  localparam int NB = XLEN / 8;

  logic [XLEN-1:0]  wdata_age [DEPTH];
  logic [NB-1:0]    be_age    [DEPTH];
  logic [DEPTH-1:0] hit_age;

  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    hit_age = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx          = head_q + PW'(k);
      wdata_age[k] = entries_q[idx].wdata;
      be_age[k]    = entries_q[idx].be;
      hit_age[k]   = hit[idx] && sb.ld_valid;
    end
  end

  sb_byte_merge #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_merge (
    .wdata_age (wdata_age),
    .be_age    (be_age),
    .hit_age   (hit_age),
    .fwd_data  (sb.fwd_data),
    .fwd_be    (sb.fwd_be)
  );

  assign sb.ld_stall = 1'b0;
`else
  assign sb.fwd_data = '0;
  assign sb.fwd_be   = '0;
  assign sb.ld_stall = sb.ld_valid && (|hit);
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: vector table for fill/drain/lookup plus
// hand sequences for wrap, simultaneous enq/drain, reset and forwarding.
module tb_store_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_buffer_if #(.XLEN(32), .DEPTH(4)) sb_if ();

  store_buffer #(.XLEN(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        enq_v;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        drain_rdy;
    logic        ld_v;
    logic [31:0] ld_addr;
    logic [2:0]  e_count;
    logic        e_dv;
    logic [31:0] e_daddr;
    logic [31:0] e_dwdata;
    logic        e_hit;
    logic [3:0]  e_fbe;
    logic [31:0] e_fdata;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(input logic ev, input logic [31:0] a, input logic dr,
                              input logic lv, input logic [31:0] la, input int cnt,
                              input logic [31:0] daddr, input logic h, input logic [31:0] fd);
    vec_t v;
    v.enq_v     = ev;
    v.addr      = a;
    v.wdata     = 32'hA000_0000 | a;
    v.be        = 4'hF;
    v.drain_rdy = dr;
    v.ld_v      = lv;
    v.ld_addr   = la;
    v.e_count   = 3'(cnt);
    v.e_dv      = (cnt != 0);
    v.e_daddr   = daddr;
    v.e_dwdata  = 32'hA000_0000 | daddr;
    v.e_hit     = h;
    v.e_fbe     = h ? 4'hF : 4'h0;
    v.e_fdata   = h ? fd : 32'h0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.enq_valid   = 1'b0;
    sb_if.enq_addr    = '0;
    sb_if.enq_wdata   = '0;
    sb_if.enq_be      = '0;
    sb_if.drain_ready = 1'b0;
    sb_if.ld_valid    = 1'b0;
    sb_if.ld_addr     = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    sb_if.enq_valid = 1'b1;
    sb_if.enq_addr  = a;
    sb_if.enq_wdata = d;
    sb_if.enq_be    = be;
  endtask

  task automatic chk_status(input string tag, input int cnt);
    chk({tag, ".count"},       32'(sb_if.count),       32'(cnt));
    chk({tag, ".empty"},       32'(sb_if.empty),       32'(cnt == 0));
    chk({tag, ".full"},        32'(sb_if.full),        32'(cnt == 4));
    chk({tag, ".drain_valid"}, 32'(sb_if.drain_valid), 32'(cnt != 0));
    chk({tag, ".enq_ready"},   32'(sb_if.enq_ready),   32'(cnt != 4));
  endtask

  task automatic chk_ld(input string tag, input logic h, input logic [3:0] fbe, input logic [31:0] fdata);
`ifdef STORE_BUFFER_FWD_EN
    chk({tag, ".fwd_be"},   32'(sb_if.fwd_be),   32'(fbe));
    chk({tag, ".fwd_data"}, sb_if.fwd_data,      fdata);
    chk({tag, ".ld_stall"}, 32'(sb_if.ld_stall), 32'h0);
`else
    chk({tag, ".ld_stall"}, 32'(sb_if.ld_stall), 32'(h));
    chk({tag, ".fwd_be"},   32'(sb_if.fwd_be),   32'h0);
    chk({tag, ".fwd_data"}, sb_if.fwd_data,      32'h0);
`endif
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 0, 32'h000, 1'b0, 32'h0);
    vecs[1]  = mk(1'b1, 32'h104, 1'b0, 1'b0, 32'h100, 1, 32'h100, 1'b0, 32'h0);
    vecs[2]  = mk(1'b1, 32'h108, 1'b0, 1'b1, 32'h102, 2, 32'h100, 1'b1, 32'hA000_0100);
    vecs[3]  = mk(1'b1, 32'h10C, 1'b0, 1'b1, 32'h200, 3, 32'h100, 1'b0, 32'h0);
    vecs[4]  = mk(1'b1, 32'h110, 1'b0, 1'b1, 32'h108, 4, 32'h100, 1'b1, 32'hA000_0108);
    vecs[5]  = mk(1'b0, 32'h000, 1'b1, 1'b0, 32'h100, 4, 32'h100, 1'b0, 32'h0);
    vecs[6]  = mk(1'b0, 32'h000, 1'b1, 1'b1, 32'h100, 3, 32'h104, 1'b0, 32'h0);
    vecs[7]  = mk(1'b0, 32'h000, 1'b1, 1'b1, 32'h108, 2, 32'h108, 1'b1, 32'hA000_0108);
    vecs[8]  = mk(1'b0, 32'h000, 1'b1, 1'b1, 32'h10C, 1, 32'h10C, 1'b1, 32'hA000_010C);
    vecs[9]  = mk(1'b0, 32'h000, 1'b1, 1'b1, 32'h110, 0, 32'h000, 1'b0, 32'h0);
    vecs[10] = mk(1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 0, 32'h000, 1'b0, 32'h0);

    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_status("reset", 0);

    // Fill to full, drop a fifth store, drain in order, lookups along the way.
    for (int i = 0; i < 11; i++) begin
      sb_if.enq_valid   = vecs[i].enq_v;
      sb_if.enq_addr    = vecs[i].addr;
      sb_if.enq_wdata   = vecs[i].wdata;
      sb_if.enq_be      = vecs[i].be;
      sb_if.drain_ready = vecs[i].drain_rdy;
      sb_if.ld_valid    = vecs[i].ld_v;
      sb_if.ld_addr     = vecs[i].ld_addr;
      #1;
      chk_status($sformatf("v%0d", i), int'(vecs[i].e_count));
      if (vecs[i].e_dv) begin
        chk($sformatf("v%0d.drain_addr", i),  sb_if.drain_addr,       vecs[i].e_daddr);
        chk($sformatf("v%0d.drain_wdata", i), sb_if.drain_wdata,      vecs[i].e_dwdata);
        chk($sformatf("v%0d.drain_be", i),    32'(sb_if.drain_be),    32'hF);
      end
      chk_ld($sformatf("v%0d", i), vecs[i].e_hit, vecs[i].e_fbe, vecs[i].e_fdata);
      tick();
    end

    // Wrap: one store in flight, enqueue and drain together for ten stores.
    do_reset();
    sb_if.drain_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) enq(32'h400 + 32'(4 * k), 32'hB000_0000 + 32'(k), 4'hF);
      else sb_if.enq_valid = 1'b0;
      #1;
      chk($sformatf("wrap%0d.count", k), 32'(sb_if.count), (k == 0) ? 32'd0 : 32'd1);
      if (k > 0) begin
        chk($sformatf("wrap%0d.drain_addr", k),  sb_if.drain_addr,  32'h400 + 32'(4 * (k - 1)));
        chk($sformatf("wrap%0d.drain_wdata", k), sb_if.drain_wdata, 32'hB000_0000 + 32'(k - 1));
      end
      tick();
    end
    idle();
    #1;
    chk_status("wrap_end", 0);

    // Simultaneous enqueue and drain at count 2, then reset with three buffered.
    do_reset();
    enq(32'h500, 32'h1, 4'hF);
    tick();
    enq(32'h504, 32'h2, 4'hF);
    tick();
    enq(32'h508, 32'h3, 4'hF);
    sb_if.drain_ready = 1'b1;
    tick();
    sb_if.drain_ready = 1'b0;
    sb_if.enq_valid   = 1'b0;
    #1;
    chk("simul.count", 32'(sb_if.count), 32'd2);
    chk("simul.drain_addr", sb_if.drain_addr, 32'h504);
    enq(32'h50C, 32'h4, 4'hF);
    tick();
    sb_if.enq_valid = 1'b0;
    #1;
    chk("pre_rst.count", 32'(sb_if.count), 32'd3);
    rst = 1'b1;
    enq(32'h510, 32'h5, 4'hF);
    sb_if.drain_ready = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    sb_if.ld_valid = 1'b1;
    sb_if.ld_addr  = 32'h504;
    #1;
    chk_status("mid_rst", 0);
    chk_ld("mid_rst", 1'b0, 4'h0, 32'h0);

`ifdef STORE_BUFFER_FWD_EN
    // Younger byte store overlays an older word store.
    do_reset();
    enq(32'h100, 32'hAABB_CCDD, 4'hF);
    tick();
    enq(32'h101, 32'h0000_1100, 4'h2);
    tick();
    sb_if.enq_valid = 1'b0;
    sb_if.ld_valid  = 1'b1;
    sb_if.ld_addr   = 32'h100;
    #1;
    chk_ld("merge", 1'b1, 4'hF, 32'hAABB_11DD);
    sb_if.ld_valid = 1'b0;
    #1;
    chk_ld("merge_ldoff", 1'b0, 4'h0, 32'h0);

    // Halfword store covers only the upper lanes.
    do_reset();
    enq(32'h202, 32'h1234_0000, 4'hC);
    tick();
    sb_if.enq_valid = 1'b0;
    sb_if.ld_valid  = 1'b1;
    sb_if.ld_addr   = 32'h200;
    #1;
    chk_ld("partial", 1'b1, 4'hC, 32'h1234_0000);
    sb_if.ld_addr = 32'h204;
    #1;
    chk_ld("partial_miss", 1'b0, 4'h0, 32'h0);
`else
    // Load to a buffered word stalls until the store has drained.
    do_reset();
    enq(32'h300, 32'hDEAD_BEEF, 4'hF);
    tick();
    sb_if.enq_valid = 1'b0;
    sb_if.ld_valid  = 1'b1;
    sb_if.ld_addr   = 32'h300;
    #1;
    chk_ld("stall", 1'b1, 4'h0, 32'h0);
    sb_if.drain_ready = 1'b1;
    #1;
    chk_ld("stall_draining", 1'b1, 4'h0, 32'h0);
    tick();
    sb_if.drain_ready = 1'b0;
    #1;
    chk_ld("stall_cleared", 1'b0, 4'h0, 32'h0);
    chk("stall_cleared.empty", 32'(sb_if.empty), 32'h1);
    sb_if.ld_valid = 1'b0;
    #1;
    chk_ld("ldoff", 1'b0, 4'h0, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
